// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
//
// Generates the CPU clock (slowClk) from the fast system clock. Two modes:
//   auto   : free-running divider, slowClk high and low for D fastClk cycles
//            each, where D = max(clockDivider, 1).
//   manual : each debounced press of stepBtn produces exactly one slowClk
//            cycle (D cycles high, then low and idle).
// A halt request stops new rising edges but never truncates a high phase.
//
// Ports
//   fastClk       in   system clock, all state updates on its rising edge
//   rst_n         in   synchronous reset, active low
//   clockDivider  in   half-period of slowClk in fastClk cycles (0 acts as 1)
//   mode          in   0 = auto, 1 = manual single step
//   halt          in   synchronous halt request from the CPU HLT logic
//   stepBtn       in   raw asynchronous pushbutton level, active high
//   slowClk       out  registered CPU clock
//   risePulse     out  one-cycle strobe, high in the first cycle slowClk is 1
//   fallPulse     out  one-cycle strobe, high in the first cycle slowClk is 0
//   running       out  auto mode with halt low, or manual high phase active
// -----------------------------------------------------------------------------
module clock_ctrl #(
    parameter int DIV_WIDTH       = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 fastClk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] clockDivider,
    input  logic                 mode,
    input  logic                 halt,
    input  logic                 stepBtn,
    output logic                 slowClk,
    output logic                 risePulse,
    output logic                 fallPulse,
    output logic                 running
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    // The phase register is the slowClk flop itself.
    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    phase_t                 phase_q,     phase_d;
    logic [DIV_WIDTH-1:0]   cnt_q,       cnt_d;
    logic                   mode_q,      mode_d;
    logic                   rise_q,      rise_d;
    logic                   fall_q,      fall_d;
    logic                   running_q,   running_d;

    logic                   sync_meta_q, sync_meta_d;
    logic                   sync_q,      sync_d;
    logic                   db_level_q,  db_level_d;
    logic [DB_W-1:0]        db_cnt_q,    db_cnt_d;
    logic                   db_prev_q,   db_prev_d;

    logic [DIV_WIDTH-1:0]   div_eff;
    logic                   phase_done;
    logic                   press;

    // -------------------------------------------------------------------------
    // Pushbutton: two-flop synchroniser followed by a debounce filter
    // -------------------------------------------------------------------------
    always_comb begin
        sync_meta_d = stepBtn;
        sync_d      = sync_meta_q;
    end

    // The accepted level moves only after the synchronised input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any cycle of
    // agreement (a bounce back) restarts the count from zero.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        db_prev_d = db_level_q;
    end

    // Single-cycle strobe on a debounced 0->1 edge. Holding the button
    // produces no further strobes, and a strobe that is not consumed in its
    // cycle is simply lost, so presses are never queued.
    assign press = db_level_q & ~db_prev_q;

    // -------------------------------------------------------------------------
    // Phase control
    // -------------------------------------------------------------------------
    assign div_eff = (clockDivider == '0) ? DIV_WIDTH'(1) : clockDivider;

    // ">=" rather than "==" so that lowering the divider mid-phase ends the
    // phase on the next cycle instead of wrapping the counter.
    assign phase_done = (cnt_q >= (div_eff - DIV_WIDTH'(1)));

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (phase_q)
            PH_HIGH: begin
                // A high phase always runs to completion, regardless of
                // halt or a pending mode change.
                if (phase_done) begin
                    phase_d = PH_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end

            default: begin
                if (mode != mode_q) begin
                    // Mode switches only land while slowClk is low and
                    // restart the low phase from zero.
                    mode_d = mode;
                    cnt_d  = '0;
                end else if (halt) begin
                    // Halted: hold off the rising edge, and restart the full
                    // low phase once halt drops.
                    cnt_d = '0;
                end else if (mode_q == MODE_AUTO) begin
                    if (phase_done) begin
                        phase_d = PH_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DIV_WIDTH'(1);
                    end
                end else begin
                    // Manual idle: wait for a press; the counter is unused.
                    cnt_d = '0;
                    if (press) begin
                        phase_d = PH_HIGH;
                        rise_d  = 1'b1;
                    end
                end
            end
        endcase

        running_d = ((mode_d == MODE_AUTO) && !halt) ||
                    ((mode_d == MODE_MANUAL) && (phase_d == PH_HIGH));
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge fastClk) begin
        if (!rst_n) begin
            phase_q     <= PH_LOW;
            cnt_q       <= '0;
            mode_q      <= MODE_AUTO;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            running_q   <= 1'b0;
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            db_level_q  <= 1'b0;
            db_cnt_q    <= '0;
            db_prev_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            running_q   <= running_d;
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            db_level_q  <= db_level_d;
            db_cnt_q    <= db_cnt_d;
            db_prev_q   <= db_prev_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all straight from flops
    // -------------------------------------------------------------------------
    assign slowClk   = (phase_q == PH_HIGH);
    assign risePulse = rise_q;
    assign fallPulse = fall_q;
    assign running   = running_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_ctrl
//
// Directed bench for clock_ctrl with default parameters (DIV_WIDTH=32,
// DEBOUNCE_CYCLES=16). Inputs change and outputs are read 1 ns after each
// fastClk rising edge. Expected values are worked out by hand from the
// intended behaviour.
// -----------------------------------------------------------------------------
module tb_clock_ctrl;

    logic        fastClk;
    logic        rst_n;
    logic [31:0] clockDivider;
    logic        mode;
    logic        halt;
    logic        stepBtn;
    logic        slowClk;
    logic        risePulse;
    logic        fallPulse;
    logic        running;

    int n_checks = 0;
    int n_fail   = 0;

    clock_ctrl dut (
        .fastClk      (fastClk),
        .rst_n        (rst_n),
        .clockDivider (clockDivider),
        .mode         (mode),
        .halt         (halt),
        .stepBtn      (stepBtn),
        .slowClk      (slowClk),
        .risePulse    (risePulse),
        .fallPulse    (fallPulse),
        .running      (running)
    );

    initial fastClk = 1'b0;
    always #5 fastClk = ~fastClk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end else begin
            $display("ok   %s: %0d", tag, $signed(got));
        end
    endtask

    task automatic tick();
        @(posedge fastClk);
        #1;
    endtask

    // Ticks until risePulse reads 1; n = ticks taken, or -1 if limit expired.
    task automatic ticks_until_rise(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (risePulse) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int   n;
        int   mism;
        int   highs;
        int   rises;
        int   falls;
        int   fall_t;
        int   first;
        int   toggles;
        logic prev;
        logic exp_clk;

        rst_n        = 1'b0;
        clockDivider = 32'd4;
        mode         = 1'b0;
        halt         = 1'b0;
        stepBtn      = 1'b0;
        repeat (3) tick();

        // ---- reset state
        check_value("rst_slowClk",   32'(slowClk),   0);
        check_value("rst_risePulse", 32'(risePulse), 0);
        check_value("rst_fallPulse", 32'(fallPulse), 0);
        check_value("rst_running",   32'(running),   0);

        // ---- first rise D=4 cycles after reset release
        rst_n = 1'b1;
        repeat (3) tick();
        check_value("first_rise_not_early", 32'(slowClk), 0);
        check_value("running_auto", 32'(running), 1);
        tick();
        check_value("first_rise_at_D", 32'(slowClk), 1);
        check_value("first_rise_pulse", 32'(risePulse), 1);

        // ---- auto D=4: 4 high / 4 low, one-cycle strobes
        mism = 0; highs = 0; rises = 0; falls = 0;
        prev = slowClk;
        for (int t = 1; t <= 16; t++) begin
            tick();
            exp_clk = ((t % 8) < 4);
            if (slowClk !== exp_clk) mism++;
            if (risePulse !== (slowClk & ~prev)) mism++;
            if (fallPulse !== (~slowClk & prev)) mism++;
            highs += int'(slowClk);
            rises += int'(risePulse);
            falls += int'(fallPulse);
            prev = slowClk;
        end
        check_value("d4_pattern_mism", mism, 0);
        check_value("d4_high_cycles", highs, 8);
        check_value("d4_rise_pulses", rises, 2);
        check_value("d4_fall_pulses", falls, 2);

        // ---- clockDivider=0 behaves as 1: toggle every cycle
        clockDivider = 32'd0;
        toggles = 0;
        prev = slowClk;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (slowClk !== prev) toggles++;
            prev = slowClk;
        end
        check_value("div0_toggles", toggles, 10);

        // ---- D=5, halt raised 2 cycles into a high phase
        clockDivider = 32'd5;
        ticks_until_rise(30, n);
        check_value("d5_rise_seen", 32'(n > 0), 1);
        highs = 1; fall_t = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            highs += int'(slowClk);
            if (fallPulse) fall_t = t;
            if (t == 2) halt = 1'b1;
            if (t == 10) check_value("halt_running", 32'(running), 0);
        end
        check_value("halt_high_cycles", highs, 5);
        check_value("halt_fall_time", fall_t, 5);
        halt = 1'b0;
        ticks_until_rise(20, n);
        check_value("unhalt_rise_delay", n, 5);

        // ---- D=100, reset pulsed mid high phase
        clockDivider = 32'd100;
        ticks_until_rise(300, n);
        check_value("d100_period", n, 200);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        check_value("midrst_slowClk", 32'(slowClk), 0);
        check_value("midrst_fallPulse", 32'(fallPulse), 0);
        rst_n = 1'b1;
        ticks_until_rise(300, n);
        check_value("midrst_first_rise", n, 100);

        // ---- mode change during a high phase waits for the phase to end
        clockDivider = 32'd3;
        mode = 1'b1;
        highs = 0; rises = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            highs += int'(slowClk);
            rises += int'(risePulse);
        end
        check_value("modesw_high_tail", highs, 2);
        check_value("modesw_no_rise", rises, 0);
        check_value("manual_idle_running", 32'(running), 0);

        // ---- bouncing button, then a stable press
        rises = 0;
        for (int p = 0; p < 5; p++) begin
            stepBtn = 1'b1;
            repeat (4) begin tick(); rises += int'(risePulse); end
            stepBtn = 1'b0;
            repeat (4) begin tick(); rises += int'(risePulse); end
        end
        check_value("bounce_no_rise", rises, 0);
        stepBtn = 1'b1;
        first = -1; highs = 0; rises = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (slowClk && first < 0) first = k;
            highs += int'(slowClk);
            rises += int'(risePulse);
        end
        check_value("press_rise_delay", first, 19);
        check_value("press_high_cycles", highs, 3);
        check_value("press_one_rise", rises, 1);
        stepBtn = 1'b0;
        repeat (40) tick();

        // ---- second press during a long high phase is dropped
        clockDivider = 32'd60;
        stepBtn = 1'b1;
        highs = 0; rises = 0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            highs += int'(slowClk);
            rises += int'(risePulse);
            if (k == 20) stepBtn = 1'b0;
            if (k == 40) stepBtn = 1'b1;
        end
        check_value("second_press_rises", rises, 1);
        check_value("second_press_high", highs, 60);
        stepBtn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter DIV_WIDTH, default 32: width of divider input and phase counter.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable fastClk cycles required to accept a stepBtn level change; the debounce counter width is derived from it.
REQ-003 fastClk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low, sampled on fastClk rising edge.
REQ-005 clockDivider  input  DIV_WIDTH  half-period of slowClk in fastClk cycles; value 0 treated as 1.
REQ-006 mode  input  1  0 = auto (free-running divider), 1 = manual (pushbutton single-step).
REQ-007 halt  input  1  synchronous halt request from CPU HLT logic.
REQ-008 stepBtn  input  1  raw asynchronous pushbutton level, active-high.
REQ-009 slowClk  output  1  registered divided/stepped CPU clock.
REQ-010 risePulse  output  1  one-fastClk strobe, high in exactly the cycle slowClk first reads 1.
REQ-011 fallPulse  output  1  one-fastClk strobe, high in exactly the cycle slowClk first reads 0.
REQ-012 running  output  1  registered; high while in auto mode with halt low, or while a manual high phase is in progress.

Function
REQ-013 Effective divider D = max(clockDivider, 1), evaluated every cycle.
REQ-014 Phase counter increments each cycle while a phase is active; the phase ends when count >= D-1, at which point slowClk toggles and count returns to 0; the >= compare makes a reduced divider mid-phase end the phase on the next cycle.
REQ-015 Auto mode: slowClk alternates low/high phases of D cycles each; period 2*D fastClk cycles.
REQ-016 Halt: a low-to-high toggle is never issued while halt=1; count is held at 0 while slowClk=0 and halt=1.
REQ-017 If halt asserts during a high phase, that phase completes normally and slowClk then stays low; a high phase is never truncated.
REQ-018 After halt deasserts, slowClk rises after a full low phase of D cycles.
REQ-019 stepBtn passes through a two-flop synchroniser (reset 0) before debounce.
REQ-020 The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the debounce count.
REQ-021 Manual mode, idle state (slowClk=0, halt=0): a debounced 0->1 edge starts a high phase; slowClk rises the next cycle, stays high D cycles, then returns low and holds.
REQ-022 Manual mode: presses during a high phase, or while halt=1, are discarded and not queued; one press produces exactly one slowClk cycle.
REQ-023 Manual mode: holding the button never auto-repeats.
REQ-024 Mode changes are applied only while slowClk=0; count is cleared on the switch, and a change requested during a high phase takes effect after that phase ends.
REQ-025 Only registered outputs drive slowClk; no combinational path from any input to slowClk.

Reset
REQ-026 With rst_n=0 at a fastClk edge: slowClk=0, risePulse=0, fallPulse=0, running=0, count=0, synchroniser=0, debounced level=0, debounce count=0, mode latch=0 (auto).
REQ-027 Reset mid-phase aborts that phase immediately (slowClk low the next cycle) with no fallPulse.
REQ-028 The first auto rising edge after rst_n rises occurs after D cycles.

Verification
REQ-029 Auto, clockDivider=4, halt=0 -> slowClk period 8 cycles, 4 high/4 low; one risePulse and one fallPulse per period, each 1 cycle wide.
REQ-030 clockDivider=0 -> identical behaviour to clockDivider=1: slowClk toggles every cycle.
REQ-031 Auto, D=5, halt raised 2 cycles into a high phase -> high phase lasts 5 cycles, then slowClk stays low; halt dropped -> rise exactly 5 cycles later.
REQ-032 Manual, DEBOUNCE_CYCLES=16, D=3, stepBtn bounces 0/1 every 4 cycles for 40 cycles then holds 1 -> exactly one slowClk high pulse of 3 cycles, starting 2+16+1 cycles after the stable 1 begins.
REQ-033 Manual, second clean press during the high phase -> ignored; total slowClk cycles = 1.
REQ-034 Auto with D=100, rst_n pulsed low mid high phase -> slowClk=0 next cycle, no fallPulse; first rise 100 cycles after reset release.
